// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared constants for the APB master bridge: FSM state
//               encodings, ECC register-slave offsets and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Default configuration
  localparam int AMBA_WORD_DEF       = 32;
  localparam int AMBA_ADDR_WIDTH_DEF = 20;
  localparam int TIMEOUT_CYCLES_DEF  = 16;

  // Bridge FSM states
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  // ECC block register map (byte offsets)
  localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] CTRL           = 20'h0_0000;
  localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] DATA_IN        = 20'h0_0004;
  localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] CODEWORD_WIDTH = 20'h0_0008;
  localparam logic [AMBA_ADDR_WIDTH_DEF-1:0] NOISE          = 20'h0_000C;

endpackage
`default_nettype wire

// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge_if
// Description : Bundles the command/response handshake and the APB bus of
//               the master bridge.
//   master modport : bridge side (drives cmd_ready, rsp_*, PSEL, PENABLE,
//                    PWRITE, PADDR, PWDATA; samples cmd_*, PRDATA, PREADY)
//   slave modport  : environment side (host sequencer + APB register slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = AMBA_WORD_DEF,
  parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEF
);

  // Command / response side
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
  logic [AMBA_WORD-1:0]       cmd_wdata;
  logic                       rsp_valid;
  logic [AMBA_WORD-1:0]       rsp_rdata;
  logic                       rsp_err;

  // APB side
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : APB initiator issuing single read/write transfers to the ECC
//               register slave. IDLE -> SETUP -> ACCESS sequencing, with a
//               direct ACCESS -> SETUP hop for back-to-back commands.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : apb_master_bridge_if.master (cmd_*, rsp_*, APB signals)
// Build option:
//   APB_MASTER_PREADY_EN : honour PREADY in ACCESS and force completion with
//                          rsp_err=1 after TIMEOUT_CYCLES wait cycles.
//                          Undefined: ACCESS is always one cycle, rsp_err=0.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = AMBA_WORD_DEF,
  parameter int AMBA_ADDR_WIDTH = AMBA_ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  apb_master_bridge_if.master bus
);

  logic [1:0]                 state_q,     state_d;
  logic                       pwrite_q,    pwrite_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q,    pwdata_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                       rsp_err_q,   rsp_err_d;

  logic done;      // ACCESS completes this cycle
  logic timeout;   // completion forced by the wait counter
  logic cmd_ready;
  logic accept;

`ifdef APB_MASTER_PREADY_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter is zero on entry to ACCESS and advances per stalled cycle.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == ACCESS) && !done) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = (state_q == ACCESS) && !bus.PREADY && (wait_cnt_q == LAST_WAIT);
  assign done    = (state_q == ACCESS) && (bus.PREADY || timeout);

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.cmd_addr[1:0];
`else
  assign timeout = 1'b0;
  assign done    = (state_q == ACCESS);

  // PREADY and the timeout depth only matter in the wait-state build.
  logic unused_cfg;
  assign unused_cfg = ^{bus.PREADY, bus.cmd_addr[1:0], 32'(TIMEOUT_CYCLES)};
`endif

  // A command can be taken in IDLE or in the completing ACCESS cycle; held
  // low throughout reset so nothing is accepted while the bus is released.
  assign cmd_ready = !rst && ((state_q == IDLE) || done);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    // Latched command drives the APB address/data phase; word aligned.
    if (accept) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = {bus.cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
      pwdata_d = bus.cmd_wdata;
    end

    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = timeout;
      rsp_rdata_d = (pwrite_q || timeout) ? '0 : bus.PRDATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // PSEL/PENABLE decode straight from the state so reset drops them at once.
  assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE   = (state_q == ACCESS);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
